// File: rtl/ws_array_pkg.sv
// ws_array_pkg: shared defaults and state type for the systolic-array output deskew.
package ws_array_pkg;
    localparam int ACC_WIDTH_DEFAULT = 32;
    typedef enum logic [1:0] {DSK_IDLE, DSK_COLLECT, DSK_DRAIN, DSK_DONE} deskew_state_t;
endpackage

// File: rtl/ws_sync_fifo.sv
// ws_sync_fifo: synchronous FIFO; a push while full lands only if a pop happens in the same cycle.
module ws_sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout = mem[rp];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= din;
                wp <= wp + 1'b1;
            end
            if (do_pop) rp <= rp + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/ws_array_output_deskew.sv
// ws_array_output_deskew: re-aligns diagonally skewed column sums into row vectors,
// buffers them and tracks tile row counts and completion.
module ws_array_output_deskew
    import ws_array_pkg::*;
#(
    parameter int COLS       = 4,
    parameter int ACC_WIDTH  = ACC_WIDTH_DEFAULT,
    parameter int FIFO_DEPTH = 8,
    parameter int ROWS_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tile_start,
    input  logic [ROWS_W-1:0]         tile_rows,
    input  logic                      col_valid,
    input  logic [COLS*ACC_WIDTH-1:0] col_sum,
    output logic                      in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [COLS*ACC_WIDTH-1:0] out_data,
    output logic                      out_last,
    output logic                      busy,
    output logic                      tile_done,
    output logic                      overflow
);
    localparam int DW = COLS*ACC_WIDTH;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    deskew_state_t state, state_n;
    logic [COLS-2:0] vpipe;
    logic [DW-1:0] aligned;
    logic [DW:0] dout;
    logic [ROWS_W-1:0] rows, row_cnt;
    logic [CW-1:0] count, inflight;
    logic push, pop, full, empty, last_row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vpipe <= '0;
        else vpipe <= (COLS-1)'({vpipe, col_valid});
    end

    // Lane j arrives j cycles late, so it needs COLS-1-j stages to line up with lane COLS-1.
    for (genvar j = 0; j < COLS; j++) begin : g_lane
        if (j == COLS-1) begin : g_pass
            assign aligned[j*ACC_WIDTH +: ACC_WIDTH] = col_sum[j*ACC_WIDTH +: ACC_WIDTH];
        end else begin : g_dly
            logic [ACC_WIDTH-1:0] d [COLS-1-j];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < COLS-1-j; k++) d[k] <= '0;
                end else begin
                    d[0] <= col_sum[j*ACC_WIDTH +: ACC_WIDTH];
                    for (int k = 1; k < COLS-1-j; k++) d[k] <= d[k-1];
                end
            end
            assign aligned[j*ACC_WIDTH +: ACC_WIDTH] = d[COLS-2-j];
        end
    end

    always_comb begin
        inflight = '0;
        for (int k = 0; k < COLS-1; k++) inflight = inflight + CW'(vpipe[k]);
    end

    assign in_ready = CW'(FIFO_DEPTH) - count > inflight;
    assign last_row = ROWS_W'(row_cnt + 1'b1) == rows;
    assign push = vpipe[COLS-2] && state == DSK_COLLECT;
    assign out_valid = !empty;
    assign pop = out_valid && out_ready;
    assign {out_last, out_data} = dout;
    assign busy = state != DSK_IDLE;
    assign tile_done = state == DSK_DONE;

    ws_sync_fifo #(.WIDTH(DW+1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .din({last_row, aligned}),
        .dout(dout), .full(full), .empty(empty), .count(count)
    );

    // A dropped last row never reaches the head of the FIFO, so DRAIN also exits on empty.
    always_comb begin
        state_n = state == DSK_IDLE    ? (tile_start ? (tile_rows == '0 ? DSK_DONE : DSK_COLLECT) : DSK_IDLE)
                : state == DSK_COLLECT ? (push && last_row ? DSK_DRAIN : DSK_COLLECT)
                : state == DSK_DRAIN   ? (empty || (pop && out_last) ? DSK_DONE : DSK_DRAIN)
                : DSK_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DSK_IDLE;
            rows <= '0;
            row_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_n;
            if (state == DSK_IDLE && tile_start) begin
                rows <= tile_rows;
                row_cnt <= '0;
                overflow <= 1'b0;
            end
            if (push) row_cnt <= row_cnt + 1'b1;
            if (push && full && !pop) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ws_array_output_deskew.sv
// tb_ws_array_output_deskew: table vectors, directed corner sequences and random tiles
// checked every cycle against a queue-based model of the deskew reader.
module tb_ws_array_output_deskew;
    localparam int COLS = 4, W = 32, DEPTH = 8, RW = 16, DW = COLS*W;

    logic clk = 0, rst = 1, tile_start = 0, col_valid = 0, out_ready = 0;
    logic [RW-1:0] tile_rows = '0;
    logic [DW-1:0] col_sum = '0, out_data;
    logic in_ready, out_valid, out_last, busy, tile_done, overflow;

    always #5 clk = ~clk;

    ws_array_output_deskew #(.COLS(COLS), .ACC_WIDTH(W), .FIFO_DEPTH(DEPTH), .ROWS_W(RW)) dut (
        .clk(clk), .rst(rst), .tile_start(tile_start), .tile_rows(tile_rows),
        .col_valid(col_valid), .col_sum(col_sum), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy),
        .tile_done(tile_done), .overflow(overflow)
    );

    typedef struct { logic [DW-1:0] data; logic last; } vec_t;
    vec_t tbl[5];

    int n_chk = 0, n_fail = 0, cyc_n = 0, n_done = 0, first_ov = -1;
    logic [DW:0] mq[$], got[$];
    logic hv[COLS-1];
    logic [DW-1:0] hd[COLS-1];
    int m_phase = 0, m_cnt = 0, m_rows = 0;
    logic m_ovf = 0;

    task automatic chk(string nm, logic [DW:0] act, logic [DW:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc_n, act, exp);
        end
    endtask

    task automatic chkb(string nm, logic act, logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %b expected %b", nm, cyc_n, act, exp);
        end
    endtask

    task automatic chki(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mkrow(int r);
        logic [DW-1:0] d;
        for (int j = 0; j < COLS; j++) d[j*W +: W] = W'(100*r + j);
        return d;
    endfunction

    task automatic m_clear();
        mq.delete();
        for (int k = 0; k < COLS-1; k++) begin
            hv[k] = 0;
            hd[k] = '0;
        end
        m_phase = 0;
        m_cnt = 0;
        m_rows = 0;
        m_ovf = 0;
    endtask

    // One clock: drive the skewed array outputs, advance the model, then check every output.
    // Model phases: 0 idle, 1 collecting, 2 draining, 3 done.
    task automatic cyc(input logic v, input logic [DW-1:0] row);
        logic pop, pl, pre_empty, last;
        int np, inflt;
        col_valid = v;
        for (int j = 0; j < COLS; j++)
            col_sum[j*W +: W] = j == 0 ? (v ? row[W-1:0] : W'($urandom))
                              : (hv[j-1] ? hd[j-1][j*W +: W] : W'($urandom));
        pre_empty = mq.size() == 0;
        pop = !pre_empty && out_ready;
        pl = 0;
        if (pop) begin
            pl = mq[0][DW];
            got.push_back(mq[0]);
            void'(mq.pop_front());
        end
        np = m_phase;
        if (m_phase == 0 && tile_start) begin
            m_rows = int'(tile_rows);
            m_cnt = 0;
            m_ovf = 0;
            np = tile_rows == 0 ? 3 : 1;
        end else if (m_phase == 1 && hv[COLS-2]) begin
            last = m_cnt + 1 == m_rows;
            if (mq.size() < DEPTH) mq.push_back({last, hd[COLS-2]});
            else m_ovf = 1;
            m_cnt++;
            if (last) np = 2;
        end else if (m_phase == 2 && ((pop && pl) || pre_empty)) np = 3;
        else if (m_phase == 3) np = 0;
        @(posedge clk);
        #1;
        cyc_n++;
        tile_start = 0;
        for (int k = COLS-2; k > 0; k--) begin
            hv[k] = hv[k-1];
            hd[k] = hd[k-1];
        end
        hv[0] = v;
        hd[0] = row;
        m_phase = np;
        inflt = 0;
        for (int k = 0; k < COLS-1; k++) inflt += int'(hv[k]);
        chkb("out_valid", out_valid, mq.size() > 0);
        if (mq.size() > 0) chk("out_row", {out_last, out_data}, mq[0]);
        chkb("in_ready", in_ready, (DEPTH - mq.size()) > inflt);
        chkb("overflow", overflow, m_ovf);
        chkb("busy", busy, m_phase != 0);
        chkb("tile_done", tile_done, m_phase == 3);
        if (tile_done) n_done++;
        if (out_valid && first_ov < 0) first_ov = cyc_n;
    endtask

    task automatic drain();
        int k = 0;
        out_ready = 1;
        while (busy && k < 100) begin
            cyc(0, '0);
            k++;
        end
        chkb("drain_timeout", busy, 1'b0);
        cyc(0, '0);
    endtask

    initial begin
        int t0, d0, sent, k, rws;
        logic saw_low, ign;
        m_clear();
        tbl[0] = '{mkrow(0), 1'b0};
        tbl[1] = '{mkrow(1), 1'b0};
        tbl[2] = '{mkrow(2), 1'b1};
        tbl[3] = '{{32'h80000000, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF}, 1'b0};
        tbl[4] = '{{32'h00000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000}, 1'b1};
        #1;
        chkb("rst_out_valid", out_valid, 0);
        chkb("rst_in_ready", in_ready, 1);
        chk("rst_out_row", {out_last, out_data}, '0);
        chkb("rst_busy", busy, 0);
        chkb("rst_tile_done", tile_done, 0);
        chkb("rst_overflow", overflow, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 0;

        // Tiles of 3 and 2 rows from the vector table, including extreme lane values.
        got.delete();
        d0 = n_done;
        out_ready = 1;
        t0 = cyc_n;
        first_ov = -1;
        for (int i = 0; i < 5; i++) begin
            if (i == 0 || i == 3) begin
                tile_rows = i == 0 ? 16'd3 : 16'd2;
                tile_start = 1;
            end
            cyc(1, tbl[i].data);
            if (i == 2 || i == 4) drain();
        end
        chki("latency", first_ov - t0, COLS);
        chki("table_rows", got.size(), 5);
        for (int i = 0; i < 5 && i < got.size(); i++) chk("table_row", got[i], {tbl[i].last, tbl[i].data});
        chki("table_done", n_done - d0, 2);

        // Backpressure with credit honoured: 12 rows, no drops.
        got.delete();
        out_ready = 0;
        tile_rows = 12;
        tile_start = 1;
        sent = 0;
        k = 0;
        saw_low = 0;
        while (sent < 12 && k < 200) begin
            if (k == 25) out_ready = 1;
            if (!in_ready && !out_ready) saw_low = 1;
            ign = in_ready;
            cyc(ign, mkrow(sent + 10));
            sent += int'(ign);
            k++;
        end
        drain();
        chkb("credit_in_ready_low", saw_low, 1);
        chkb("credit_no_overflow", overflow, 0);
        chki("credit_rows", got.size(), 12);
        for (int i = 0; i < 12 && i < got.size(); i++) chk("credit_row", got[i], {i == 11, mkrow(i + 10)});

        // Credit ignored: 10 rows into 8 entries, last two dropped.
        got.delete();
        d0 = n_done;
        out_ready = 0;
        tile_rows = 10;
        tile_start = 1;
        for (int i = 0; i < 10; i++) cyc(1, mkrow(i + 30));
        repeat (5) cyc(0, '0);
        chkb("ovf_set", overflow, 1);
        drain();
        chki("ovf_rows", got.size(), 8);
        for (int i = 0; i < 8 && i < got.size(); i++) chk("ovf_row", got[i], {1'b0, mkrow(i + 30)});
        chkb("ovf_sticky", overflow, 1);
        chki("ovf_done", n_done - d0, 1);

        // Zero-row tile plus an ignored tile_start while busy.
        got.delete();
        d0 = n_done;
        tile_rows = 0;
        tile_start = 1;
        cyc(0, '0);
        tile_rows = 5;
        tile_start = 1;
        cyc(0, '0);
        repeat (3) cyc(0, '0);
        chki("zero_done", n_done - d0, 1);
        chki("zero_rows", got.size(), 0);
        chkb("zero_idle", busy, 0);
        chkb("zero_ovf_cleared", overflow, 0);

        // Async reset mid-DRAIN with 3 rows buffered.
        got.delete();
        out_ready = 0;
        tile_rows = 3;
        tile_start = 1;
        for (int i = 0; i < 3; i++) cyc(1, mkrow(i + 50));
        repeat (5) cyc(0, '0);
        chkb("pre_rst_busy", busy, 1);
        chkb("pre_rst_valid", out_valid, 1);
        d0 = n_done;
        #3 rst = 1;
        #1;
        chkb("rst_mid_valid", out_valid, 0);
        chkb("rst_mid_busy", busy, 0);
        chkb("rst_mid_done", tile_done, 0);
        @(posedge clk);
        #1;
        rst = 0;
        col_valid = 0;
        m_clear();
        got.delete();
        out_ready = 1;
        tile_rows = 2;
        tile_start = 1;
        for (int i = 0; i < 2; i++) cyc(1, mkrow(i + 60));
        drain();
        chki("post_rst_rows", got.size(), 2);
        for (int i = 0; i < 2 && i < got.size(); i++) chk("post_rst_row", got[i], {i == 1, mkrow(i + 60)});
        chki("post_rst_done", n_done - d0, 1);

        // Random tiles against the model; every fourth tile ignores the credit.
        for (int t = 0; t < 24; t++) begin
            rws = $urandom_range(1, 12);
            tile_rows = RW'(rws);
            tile_start = 1;
            ign = t % 4 == 3;
            sent = 0;
            k = 0;
            while (sent < rws && k < 500) begin
                logic v;
                out_ready = 1'($urandom_range(0, 1));
                v = (ign || in_ready) && $urandom_range(0, 2) != 0;
                cyc(v, {$urandom, $urandom, $urandom, $urandom});
                sent += int'(v);
                k++;
            end
            chki("rand_send_timeout", sent, rws);
            drain();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end
endmodule
